// File: rtl/bp_access_sched.sv
// Arbitrates the gshare predictor's single BHT/GHR port between fetch lookups and
// queued execute-stage updates, shaping the start/update pulses the predictor expects.
module bp_access_sched #(
    parameter int ADDR_BITS    = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_req,
    input  logic [ADDR_BITS-1:0] fetch_addr,
    input  logic [6:0]           fetch_opcode,
    output logic                 fetch_gnt,
    output logic                 pred_valid,
    output logic                 pred_taken,
    input  logic                 res_valid,
    input  logic [ADDR_BITS-1:0] res_addr,
    input  logic                 res_taken,
    input  logic                 res_predicted,
    output logic                 res_ready,
    output logic                 mispredict,
    output logic                 bp_start,
    output logic [ADDR_BITS-1:0] bp_addr,
    output logic [6:0]           bp_opcode,
    input  logic                 bp_prediction,
    output logic                 bp_update,
    output logic [ADDR_BITS-1:0] bp_update_addr,
    output logic                 bp_taken
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0] STARVE_MAX    = STV_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_LOOK, S_UPD} state_t;

    state_t state_reg, state_next;

    logic [ADDR_BITS-1:0] addr_mem  [FIFO_DEPTH];
    logic                 taken_mem [FIFO_DEPTH];

    logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg;
    logic [STV_W-1:0]     starve_reg;
    logic [ADDR_BITS-1:0] bp_addr_reg, bp_update_addr_reg;
    logic [6:0]           bp_opcode_reg;
    logic                 bp_taken_reg, pred_valid_reg, pred_taken_reg, mispredict_reg;

    logic fifo_full, fifo_empty, push, upd_elig, upd_win, look_win;

    assign fifo_full  = (count_reg == FIFO_FULL_CNT);
    assign fifo_empty = (count_reg == '0);
    assign res_ready  = !fifo_full && !rst;
    assign push       = res_valid && res_ready;
    // Forcing a gap after every update lets bp_update fall before the next rising edge.
    assign upd_elig   = !fifo_empty && (state_reg != S_UPD);

    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        upd_win    = 1'b0;
        look_win   = 1'b0;
        state_next = S_IDLE;
        if (upd_elig && (fifo_full || starve_reg == STARVE_MAX || !fetch_req)) begin
            upd_win    = 1'b1;
            state_next = S_UPD;
        end else if (fetch_req) begin
            look_win   = 1'b1;
            state_next = S_LOOK;
        end
    end

    always_comb begin
        fetch_gnt = look_win && !rst;
        bp_start  = (state_reg == S_LOOK) && !rst;
        bp_update = (state_reg == S_UPD) && !rst;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_reg]  <= res_addr;
            taken_mem[wr_ptr_reg] <= res_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)    wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (upd_win) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, upd_win})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_reg         <= '0;
            bp_addr_reg        <= '0;
            bp_opcode_reg      <= '0;
            bp_update_addr_reg <= '0;
            bp_taken_reg       <= 1'b0;
            pred_valid_reg     <= 1'b0;
            pred_taken_reg     <= 1'b0;
            mispredict_reg     <= 1'b0;
        end else begin
            if (upd_win || fifo_empty)
                starve_reg <= '0;
            else if (upd_elig && look_win && starve_reg != STARVE_MAX)
                starve_reg <= starve_reg + STV_W'(1);
            if (look_win) begin
                bp_addr_reg   <= fetch_addr;
                bp_opcode_reg <= fetch_opcode;
            end
            if (upd_win) begin
                bp_update_addr_reg <= addr_mem[rd_ptr_reg];
                bp_taken_reg       <= taken_mem[rd_ptr_reg];
            end
            pred_valid_reg <= bp_start;
            pred_taken_reg <= bp_start && bp_prediction;
            mispredict_reg <= push && (res_taken != res_predicted);
        end
    end

    // Registered flags are masked so nothing queued before reset leaks out during it.
    assign pred_valid     = pred_valid_reg && !rst;
    assign pred_taken     = pred_taken_reg && !rst;
    assign mispredict     = mispredict_reg && !rst;
    assign bp_addr        = bp_addr_reg;
    assign bp_opcode      = bp_opcode_reg;
    assign bp_update_addr = bp_update_addr_reg;
    assign bp_taken       = bp_taken_reg;
endmodule

// File: tb/tb_bp_access_sched.sv
// Scoreboard bench for bp_access_sched: queue-level reference model plus output monitor.
module tb_bp_access_sched;
    localparam int AB = 8;
    localparam int FD = 4;
    localparam int SL = 4;

    logic clk = 1'b0;
    logic rst, fetch_req, fetch_gnt, pred_valid, pred_taken;
    logic [AB-1:0] fetch_addr, res_addr, bp_addr, bp_update_addr;
    logic [6:0] fetch_opcode, bp_opcode;
    logic res_valid, res_taken, res_predicted, res_ready, mispredict;
    logic bp_start, bp_prediction, bp_update, bp_taken;

    always #5 clk = ~clk;

    bp_access_sched #(.ADDR_BITS(AB), .FIFO_DEPTH(FD), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_opcode(fetch_opcode),
        .fetch_gnt(fetch_gnt), .pred_valid(pred_valid), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_addr(res_addr), .res_taken(res_taken),
        .res_predicted(res_predicted), .res_ready(res_ready), .mispredict(mispredict),
        .bp_start(bp_start), .bp_addr(bp_addr), .bp_opcode(bp_opcode),
        .bp_prediction(bp_prediction), .bp_update(bp_update),
        .bp_update_addr(bp_update_addr), .bp_taken(bp_taken)
    );

    // Predictor stand-in: a fixed function of the looked-up address.
    assign bp_prediction = bp_addr[0] ^ bp_addr[3];

    typedef struct {
        int         cyc;
        logic [7:0] a;
        logic [6:0] b;
    } exp_t;

    exp_t start_q[$], pred_q[$], upd_q[$], mis_q[$];
    exp_t mq[$];
    int   cyc = 0;
    int   total = 0, passed = 0;
    int   starve = 0;
    bit   last_upd = 0, last_gnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // One cycle: drive inputs just after the edge, then advance the reference model.
    task automatic step(input logic r, input logic fr, input logic [7:0] fa, input logic [6:0] fo,
                        input logic rv, input logic [7:0] ra, input logic rt, input logic rp);
        bit full, empty, ready, elig, upd, look;
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; fetch_req = fr; fetch_addr = fa; fetch_opcode = fo;
        res_valid = rv; res_addr = ra; res_taken = rt; res_predicted = rp;
        #1;
        if (r) begin
            chk("fetch_gnt_rst", fetch_gnt, 0);
            chk("res_ready_rst", res_ready, 0);
            mq.delete(); start_q.delete(); pred_q.delete(); upd_q.delete(); mis_q.delete();
            starve = 0; last_upd = 0; last_gnt = 0;
            return;
        end
        full  = (mq.size() == FD);
        empty = (mq.size() == 0);
        ready = !full;
        elig  = !empty && !last_upd;
        upd   = elig && (full || starve == SL || !fr);
        look  = !upd && fr;
        chk("fetch_gnt", fetch_gnt, look);
        chk("res_ready", res_ready, ready);
        if (upd || empty) starve = 0;
        else if (elig && look && starve < SL) starve++;
        if (upd) begin
            e = mq.pop_front();
            e.cyc = cyc + 1;
            upd_q.push_back(e);
        end
        if (look) begin
            e.cyc = cyc + 1; e.a = fa; e.b = fo;
            start_q.push_back(e);
            e.cyc = cyc + 2; e.a = {7'd0, fa[0] ^ fa[3]}; e.b = 0;
            pred_q.push_back(e);
        end
        if (rv && ready) begin
            e.cyc = 0; e.a = ra; e.b = {6'd0, rt};
            mq.push_back(e);
            if (rt != rp) begin
                e.cyc = cyc + 1;
                mis_q.push_back(e);
            end
        end
        last_upd = upd;
        last_gnt = look;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: consumes expected events whenever the DUT presents the matching output.
    always @(negedge clk) begin
        exp_t e;
        if (start_q.size() > 0 && start_q[0].cyc < cyc) begin
            chk("bp_start_missed", cyc, start_q[0].cyc); void'(start_q.pop_front());
        end
        if (pred_q.size() > 0 && pred_q[0].cyc < cyc) begin
            chk("pred_valid_missed", cyc, pred_q[0].cyc); void'(pred_q.pop_front());
        end
        if (upd_q.size() > 0 && upd_q[0].cyc < cyc) begin
            chk("bp_update_missed", cyc, upd_q[0].cyc); void'(upd_q.pop_front());
        end
        if (mis_q.size() > 0 && mis_q[0].cyc < cyc) begin
            chk("mispredict_missed", cyc, mis_q[0].cyc); void'(mis_q.pop_front());
        end
        if (bp_start === 1'b1) begin
            if (start_q.size() == 0) chk("bp_start_unexpected", start_q.size(), 1);
            else begin
                e = start_q.pop_front();
                chk("bp_start_cycle", cyc, e.cyc);
                chk("bp_addr", bp_addr, e.a);
                chk("bp_opcode", bp_opcode, e.b);
            end
        end
        if (pred_valid === 1'b1) begin
            if (pred_q.size() == 0) chk("pred_valid_unexpected", pred_q.size(), 1);
            else begin
                e = pred_q.pop_front();
                chk("pred_cycle", cyc, e.cyc);
                chk("pred_taken", pred_taken, e.a);
            end
        end
        if (bp_update === 1'b1) begin
            if (upd_q.size() == 0) chk("bp_update_unexpected", upd_q.size(), 1);
            else begin
                e = upd_q.pop_front();
                chk("bp_update_cycle", cyc, e.cyc);
                chk("bp_update_addr", bp_update_addr, e.a);
                chk("bp_taken", bp_taken, e.b);
            end
            if (bp_start === 1'b1) chk("start_update_overlap", bp_start, 0);
        end
        if (mispredict === 1'b1) begin
            if (mis_q.size() == 0) chk("mispredict_unexpected", mis_q.size(), 1);
            else begin
                e = mis_q.pop_front();
                chk("mispredict_cycle", cyc, e.cyc);
            end
        end
    end

    logic       fr_r;
    logic [7:0] fa_r;
    logic [6:0] fo_r;
    int         res_pct;

    initial begin
        rst = 1; fetch_req = 0; fetch_addr = 0; fetch_opcode = 0;
        res_valid = 0; res_addr = 0; res_taken = 0; res_predicted = 0;
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_bp_start", bp_start, 0);
        chk("rst_bp_update", bp_update, 0);
        chk("rst_pred_valid", pred_valid, 0);
        chk("rst_pred_taken", pred_taken, 0);
        chk("rst_mispredict", mispredict, 0);
        chk("rst_bp_addr", bp_addr, 0);
        chk("rst_bp_opcode", bp_opcode, 0);
        chk("rst_bp_update_addr", bp_update_addr, 0);
        chk("rst_bp_taken", bp_taken, 0);

        // Single lookup
        step(0, 1, 8'h3C, 7'h63, 0, 0, 0, 0);
        idle(3);
        // Three queued updates with fetch idle
        step(0, 0, 0, 0, 1, 8'h10, 1, 1);
        step(0, 0, 0, 0, 1, 8'h11, 0, 0);
        step(0, 0, 0, 0, 1, 8'h12, 1, 1);
        idle(6);
        // Starvation: one update against a continuous fetch stream
        step(0, 1, 8'h40, 7'h13, 1, 8'h20, 1, 0);
        for (int i = 1; i < 9; i++) step(0, 1, 8'(8'h40 + i), 7'h13, 0, 0, 0, 0);
        idle(3);
        // Fill the FIFO while fetch is busy
        for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h80 + i), 7'h63, 1, 8'(8'h30 + i), i[0], 1'b0);
        for (int i = 0; i < 8; i++) step(0, 1, 8'(8'h90 + i), 7'h63, 1, 8'hA0, 1, 1);
        idle(10);
        // Reset with queued updates and a lookup in flight
        step(0, 1, 8'h55, 7'h67, 1, 8'h61, 1, 1);
        step(0, 1, 8'h56, 7'h67, 1, 8'h62, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(6);

        fr_r = 0; fa_r = 0; fo_r = 0; res_pct = 50;
        for (int c = 0; c < 2500; c++) begin
            if (c % 100 == 0) res_pct = $urandom_range(10, 95);
            if (!(fr_r && !last_gnt)) begin
                fr_r = ($urandom_range(0, 99) < 60);
                fa_r = 8'($urandom);
                fo_r = 7'($urandom);
            end
            if ($urandom_range(0, 399) == 0) begin
                step(1, 0, 0, 0, 0, 0, 0, 0);
                step(1, 0, 0, 0, 0, 0, 0, 0);
                fr_r = 0;
            end else begin
                step(0, fr_r, fa_r, fo_r, $urandom_range(0, 99) < res_pct,
                     8'($urandom), 1'($urandom), 1'($urandom));
            end
        end
        idle(12);
        @(negedge clk);
        #1;
        chk("start_q_drained", start_q.size(), 0);
        chk("pred_q_drained", pred_q.size(), 0);
        chk("upd_q_drained", upd_q.size(), 0);
        chk("mis_q_drained", mis_q.size(), 0);
        chk("model_fifo_drained", mq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/bp_access_sched.md
# bp_access_sched

Access scheduler for the gshare branch predictor. It shares the predictor's single BHT/GHR access path between the fetch stage, which needs lookups, and the execute stage, which resolves branches and needs updates. Resolved branches are buffered in a small FIFO. The block drives the predictor's `start`/`update` controls with correctly shaped pulses and returns registered predictions to fetch. It sits between the fetch/execute stages and the predictor instance, and flags mispredictions to the pipeline flush logic.

## Interface
- ADDR_BITS, 8, width of branch address fields (matches predictor index width)
- FIFO_DEPTH, 4, resolved-branch update queue depth (power of 2, ≥2)
- STARVE_LIMIT, 4, consecutive lost arbitrations after which a pending update beats a lookup
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- fetch_req  in  1  fetch wants a prediction; held until fetch_gnt
- fetch_addr  in  ADDR_BITS  low PC bits of branch being fetched
- fetch_opcode  in  7  opcode of fetched instruction
- fetch_gnt  out  1  combinational; lookup accepted this cycle
- pred_valid  out  1  registered; pred_taken valid this cycle
- pred_taken  out  1  registered prediction returned to fetch
- res_valid  in  1  execute presents a resolved branch
- res_addr  in  ADDR_BITS  low PC bits of resolved branch
- res_taken  in  1  actual outcome
- res_predicted  in  1  outcome fetch used
- res_ready  out  1  combinational; = !fifo_full && !rst
- mispredict  out  1  registered one-cycle pulse
- bp_start, bp_addr[ADDR_BITS], bp_opcode[7]  out  to predictor start/branch_address/opcode
- bp_prediction  in  1  predictor prediction output
- bp_update, bp_update_addr[ADDR_BITS], bp_taken  out  to predictor update/update_address/branch_taken

## Operation
- Resolve path: res_valid && res_ready pushes {res_addr, res_taken} into the FIFO.
  - Same edge: mispredict <= (res_taken != res_predicted); otherwise mispredict <= 0.
- Full FIFO: res_ready = 0, including a cycle that also pops. There is no same-cycle push bypass.
- Issue FSM state register, with states S_IDLE, S_LOOK and S_UPD. The state names what was granted this cycle and is issued next cycle.
- upd_elig = !fifo_empty && state != S_UPD. This enforces one non-update cycle between updates, so bp_update returns low between pulses; the predictor updates on the posedge of `update`.
- Arbitration each cycle, in priority order:
  - Update wins if upd_elig && (fifo_full || starve_cnt == STARVE_LIMIT || !fetch_req).
  - Otherwise fetch wins if fetch_req.
  - Otherwise idle.
- Grant results:
  - Fetch win: fetch_gnt = 1, next state S_LOOK.
  - Update win: pop FIFO head, next state S_UPD.
  - Neither: next state S_IDLE.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - +1 when upd_elig && a lookup is granted.
  - Cleared on an update grant or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- FIFO pointers wrap modulo FIFO_DEPTH. Occupancy count is 0..FIFO_DEPTH.

## Timing
- Lookup latency 2 cycles.
  - Grant in cycle N.
  - bp_start = 1 in N+1, with bp_addr/bp_opcode holding the granted fetch_addr/fetch_opcode.
  - pred_valid = 1 and pred_taken = bp_prediction in N+2.
- bp_start is high exactly one cycle per grant. Back-to-back lookup grants give bp_start high in consecutive cycles, each with new bp_addr.
- Update latency:
  - Pop in cycle N.
  - bp_update = 1 in N+1 only, with bp_update_addr/bp_taken = popped entry.
  - bp_update_addr/bp_taken hold their values in N+2.
  - Earliest next bp_update is N+3.
- bp_start and bp_update are never high in the same cycle.
- Outputs during and after reset, until next grant:
  - bp_start, bp_update, pred_valid, pred_taken, mispredict, bp_* addresses: 0.
  - fetch_gnt: 0; res_ready: 0 while rst = 1.
  - FIFO empty, starve_cnt 0, state S_IDLE.
- Reset mid-operation discards queued updates and in-flight lookups. A pending pred_valid or bp_update is not emitted after rst.

## Test plan
- Reset, then a single fetch_req with addr 0x3C, opcode 0x63 → fetch_gnt same cycle; bp_start with bp_addr 0x3C one cycle later; pred_valid with pred_taken = bp_prediction two cycles later.
- fetch_req idle; push 3 resolutions (0x10/1, 0x11/0, 0x12/1) back-to-back → bp_update pulses in cycles 2, 4, 6 carrying entries in order, each separated by a low cycle.
- fetch_req held continuously with 1 queued update → 4 lookups granted, then the update wins on the 5th cycle (STARVE_LIMIT = 4), then lookups resume.
- Push 4 entries with fetch_req held → res_ready = 0 at occupancy 4; update forced ahead of fetch; res_ready returns to 1 the cycle after the pop.
- Push res_taken = 1 with res_predicted = 0 → mispredict = 1 for exactly one cycle; matching values → mispredict stays 0.
- Assert rst with 2 queued entries and a lookup in flight → no bp_update or pred_valid follows; res_ready = 0 during rst; FIFO empty afterwards.
